key_event_encoder: RTL and testbench
====================================

# key_event_encoder

Input-conditioning stage directly upstream of `calculator`. It synchronises and debounces the 12 keypad buttons (`swp`) and 8 operation switches (`swd`), turns each debounced press into one encoded key event, and queues events in a small FIFO. The calculator consumes the FIFO through a valid/ready handshake, so it sees exactly one event per press regardless of how long the button is held.

## Interface
- `DB_CNT`, default 16: consecutive stable cycles required before a debounced level changes (≥2).
- `FIFO_DEPTH`, default 4: event queue depth (power of two, ≥2).
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets).
- `swp`  in  12  raw keypad buttons, active-high, asynchronous to `clk`.
- `swd`  in  8  raw operation switches, active-high, asynchronous to `clk`.
- `key_valid`  out  1  FIFO head holds an event.
- `key_code`  out  5  head event code; valid only while `key_valid`=1.
- `key_ready`  in  1  consumer accepts head this cycle.
- `overflow`  out  1  sticky: a press was merged or lost; cleared only by reset.
- `held`  out  20  debounced levels, {`swd`, `swp`}.

## Operation
- Key codes:
  - `swp[11]`..`swp[3]` map to 1..9.
  - `swp[2]` maps to 0x0A (`*`).
  - `swp[1]` maps to 0x00.
  - `swp[0]` maps to 0x0B (`#`).
  - `swd[i]` maps to 0x10+i.
  - Codes 0x0C–0x0F are never produced.
- Per input, 20 lanes in parallel:
  - Two-flop synchroniser `s1`→`s2`.
  - Debounced level `db` and a counter of width clog2(`DB_CNT`).
  - When `s2`==`db`, the counter clears.
  - Otherwise the counter increments. When the counter equals `DB_CNT`-1 and `s2`≠`db`, `db` toggles and the counter clears.
  - A single-cycle glitch shorter than `DB_CNT` cycles never changes `db`.
- Press detect: a rising edge of `db` sets that lane's `pend` bit. Falling edges produce no event.
- Encoder:
  - Each cycle, the encoder selects the pending lane with the lowest code.
  - If the FIFO is not full, or is full and being popped this cycle, it writes that code and clears that `pend` bit.
  - At most one write per cycle. Other pending lanes wait, so simultaneous presses are all delivered in ascending code order.
- Merge: a rising edge on a lane whose `pend` is already 1 sets `overflow`. The press is merged, not queued twice.
- FIFO:
  - Show-ahead: `key_code` is the head entry.
  - Pop occurs when `key_valid` and `key_ready` are both 1.
  - Write and pop may occur in the same cycle, including when full; the occupancy count is then unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `key_ready` while empty has no effect.

## Timing
- Reset values: `key_valid`=0, `key_code`=0, `overflow`=0, `held`=0. All synchronisers, counters, `pend` bits and FIFO pointers are 0.
- Reset deassertion is used unsynchronised; the team's top-level reset synchroniser provides a clean release.
- Latency: with the raw input rising before edge 0 and held stable:
  - `s2`=1 after edge 2.
  - `db`/`held` bit =1 after edge 2+`DB_CNT`.
  - `pend`=1 after edge 3+`DB_CNT`.
  - `key_valid`=1 after edge 4+`DB_CNT` (20 cycles at default).
- Throughput: one event per cycle while the consumer holds `key_ready`=1.
- `key_code` and `key_valid` are registered outputs. They change only on clock edges, or asynchronously to reset values.
- Reset mid-operation discards queued and pending events with no partial output. A button still held at release is re-detected as a new press after `DB_CNT`+4 cycles.

## Structure
- Shared package `key_pkg` holds:
  - `KEY_W`=5.
  - Code constants `KEY_STAR`=0x0A, `KEY_HASH`=0x0B, `KEY_OP_BASE`=0x10.
  - The lane-to-code mapping function.
  - `NUM_LANES`=20.
- Sub-module `key_fifo` (parameters `W`, `DEPTH`) implements the show-ahead synchronous FIFO with full, empty and count.
- Debounce lanes are a generate loop in the top; no separate module.

## Test plan
- Single press: `swp`=0x400 held 200 cycles, `key_ready`=1 → exactly one event, `key_code`=2, `key_valid` rises 20 cycles after the input. Release produces no event.
- Bounce: `swd[7]` toggling every 3 cycles for 30 cycles, then stable high (`DB_CNT`=16) → one event, `key_code`=0x17. `held[19]` never glitches.
- Simultaneous presses: `swp[10]`, `swp[9]` and `swd[0]` rise in the same cycle → codes 0x02, 0x03, 0x10 on three consecutive cycles.
- Backpressure and full: `key_ready`=0 during 6 distinct presses → the FIFO holds 4 events and 2 lanes stay pending with `overflow`=0. Raising `key_ready` then delivers all 6 in press order.
- Merge: press and release `swp[8]` twice while its `pend` is blocked by a full FIFO → `overflow`=1, and only one code 0x04 is delivered.
- Reset mid-operation: assert `rst`=0 with 3 events queued → `key_valid`=0 immediately, with no stale codes after release.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and lane-to-code mapping for the key event encoder
package key_pkg;

  localparam int KEY_W     = 5;
  localparam int NUM_LANES = 20;

  localparam logic [KEY_W-1:0] KEY_STAR    = 5'h0A;
  localparam logic [KEY_W-1:0] KEY_HASH    = 5'h0B;
  localparam logic [KEY_W-1:0] KEY_OP_BASE = 5'h10;

  // Lanes 0..11 carry swp[0..11]; lanes 12..19 carry swd[0..7].
  function automatic logic [KEY_W-1:0] lane_code(input int lane);
    logic [KEY_W-1:0] code;
    if (lane == 0)       code = KEY_HASH;
    else if (lane == 1)  code = '0;
    else if (lane == 2)  code = KEY_STAR;
    else if (lane < 12)  code = KEY_W'(12 - lane);
    else                 code = KEY_OP_BASE + KEY_W'(lane - 12);
    return code;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - show-ahead synchronous FIFO with full, empty and count
module key_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (int'(count) == DEPTH);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - debounce keypad/switch lanes and queue one code per press
module key_event_encoder
  import key_pkg::*;
#(
  parameter int DB_CNT     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          swp,
  input  logic [7:0]           swd,
  output logic                 key_valid,
  output logic [KEY_W-1:0]     key_code,
  input  logic                 key_ready,
  output logic                 overflow,
  output logic [NUM_LANES-1:0] held
);

  localparam int CNT_W  = $clog2(DB_CNT);
  localparam int LANE_W = $clog2(NUM_LANES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

  logic [NUM_LANES-1:0]        raw;
  logic [NUM_LANES-1:0]        db;
  logic [NUM_LANES-1:0]        db_q;
  logic [NUM_LANES-1:0]        rise;
  logic [NUM_LANES-1:0]        pend;
  logic [NUM_LANES-1:0]        clr;
  logic [KEY_W-1:0]            sel_code;
  logic [LANE_W-1:0]           sel_lane;
  logic                        any_pend;
  logic                        wr;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        count_unused;

  assign raw = {swd, swp};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic             s1;
    logic             s2;
    logic             lvl;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lvl <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign db[g] = lvl;
  end

  assign rise = db & ~db_q;

  // Lowest code among pending lanes wins, so simultaneous presses drain in ascending order.
  always_comb begin
    any_pend = 1'b0;
    sel_code = '0;
    sel_lane = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (pend[l] && (!any_pend || lane_code(l) < sel_code)) begin
        any_pend = 1'b1;
        sel_code = lane_code(l);
        sel_lane = LANE_W'(l);
      end
    end
  end

  assign pop = key_valid && key_ready;
  assign wr  = any_pend && (!full || pop);

  always_comb begin
    clr = '0;
    if (wr) clr[sel_lane] = 1'b1;
  end

  // A repeat press on a lane that is still pending is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q     <= '0;
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      db_q <= db;
      pend <= (pend & ~clr) | (rise & ~pend);
      if (|(rise & pend)) overflow <= 1'b1;
    end
  end

  key_fifo #(
    .W     (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .din   (sel_code),
    .pop   (pop),
    .dout  (key_code),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign count_unused = ^fifo_count;
  assign key_valid    = !empty;
  assign held         = db;

endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - self-checking bench for key_event_encoder
module tb_key_event_encoder;

  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] swp = '0;
  logic [7:0]  swd = '0;
  logic        key_ready = 1'b0;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        overflow;
  logic [19:0] held;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [4:0] got[$];
  int         got_cyc[$];
  logic [4:0] exp_q[$];

  typedef struct {
    logic [11:0] p;
    logic [7:0]  d;
    logic [4:0]  code;
  } vec_t;
  vec_t vecs[$];

  logic [4:0] swp_code [12] = '{5'h0B, 5'h00, 5'h0A, 5'h09, 5'h08, 5'h07,
                                5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
  int bp_lanes [6] = '{15, 0, 5, 13, 11, 2};
  logic [4:0] bp_exp [6] = '{5'h13, 5'h0B, 5'h07, 5'h11, 5'h01, 5'h0A};
  int mg_lanes [4] = '{11, 10, 9, 7};
  logic [4:0] mg_exp [5] = '{5'h01, 5'h02, 5'h03, 5'h05, 5'h04};

  key_event_encoder #(.DB_CNT(DB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .swp       (swp),
    .swd       (swd),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .overflow  (overflow),
    .held      (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && key_valid && key_ready) begin
      got.push_back(key_code);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rtick(input int n);
    repeat (n) begin
      key_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
  endtask

  task automatic set_lane(input int lane, input logic v);
    if (lane < 12) swp[lane] = v;
    else swd[lane-12] = v;
  endtask

  function automatic logic [4:0] ref_code(input int lane);
    return (lane < 12) ? swp_code[lane] : 5'(16 + lane - 12);
  endfunction

  function automatic logic [4:0] code_at(input int i);
    return (i < got.size()) ? got[i] : 5'h1F;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -100;
  endfunction

  task automatic wait_events(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, got.size(), n);
  endtask

  task automatic clear_got();
    got.delete();
    got_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vlat, hlat, rises, falls, lane, glane;
    logic prev;

    vecs.push_back('{12'h001, 8'h00, 5'h0B});
    vecs.push_back('{12'h002, 8'h00, 5'h00});
    vecs.push_back('{12'h004, 8'h00, 5'h0A});
    vecs.push_back('{12'h008, 8'h00, 5'h09});
    vecs.push_back('{12'h010, 8'h00, 5'h08});
    vecs.push_back('{12'h040, 8'h00, 5'h06});
    vecs.push_back('{12'h080, 8'h00, 5'h05});
    vecs.push_back('{12'h200, 8'h00, 5'h03});
    vecs.push_back('{12'h800, 8'h00, 5'h01});
    vecs.push_back('{12'h000, 8'h01, 5'h10});
    vecs.push_back('{12'h000, 8'h10, 5'h14});
    vecs.push_back('{12'h000, 8'h80, 5'h17});

    // reset state
    tick(3);
    check("reset_valid", key_valid, 0);
    check("reset_code", key_code, 0);
    check("reset_overflow", overflow, 0);
    check("reset_held", held, 0);
    rst = 1'b1;
    tick(2);

    // single press latency, one event per press, none on release
    clear_got();
    key_ready = 1'b1;
    swp = 12'h400;
    vlat = -1;
    hlat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (vlat < 0 && key_valid) vlat = k;
      if (hlat < 0 && held[10]) hlat = k;
    end
    check("single_valid_latency", vlat, DB + 4);
    check("single_held_latency", hlat, DB + 2);
    tick(160);
    swp = '0;
    tick(DB + 20);
    check("single_count", got.size(), 1);
    check("single_code", code_at(0), 5'h02);

    // table: one press per lane, code mapping
    for (int i = 0; i < vecs.size(); i++) begin
      clear_got();
      swp = vecs[i].p;
      swd = vecs[i].d;
      tick(DB + 10);
      swp = '0;
      swd = '0;
      tick(DB + 10);
      check($sformatf("vec%0d_count", i), got.size(), 1);
      check($sformatf("vec%0d_code", i), code_at(0), vecs[i].code);
    end

    // bounce on swd[7]
    clear_got();
    rises = 0;
    falls = 0;
    prev = held[19];
    for (int k = 0; k < 70; k++) begin
      swd[7] = (k >= 30) ? 1'b1 : (((k / 3) % 2) == 0);
      tick(1);
      if (held[19] && !prev) rises++;
      if (!held[19] && prev) falls++;
      prev = held[19];
    end
    check("bounce_rises", rises, 1);
    check("bounce_falls", falls, 0);
    check("bounce_count", got.size(), 1);
    check("bounce_code", code_at(0), 5'h17);
    swd = '0;
    tick(DB + 10);

    // simultaneous presses drain in ascending order, back to back
    clear_got();
    swp[10] = 1'b1;
    swp[9]  = 1'b1;
    swd[0]  = 1'b1;
    wait_events(3, 60, "simul_count");
    check("simul_code0", code_at(0), 5'h02);
    check("simul_code1", code_at(1), 5'h03);
    check("simul_code2", code_at(2), 5'h10);
    check("simul_back_to_back", cyc_at(2) - cyc_at(0), 2);
    swp = '0;
    swd = '0;
    tick(DB + 10);

    // backpressure: 4 queued, 2 pending, then full-rate drain in press order
    clear_got();
    key_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_lane(bp_lanes[i], 1'b1);
      tick(DB + 10);
    end
    check("bp_valid_full", key_valid, 1);
    check("bp_head", key_code, 5'h13);
    check("bp_overflow", overflow, 0);
    check("bp_none_popped", got.size(), 0);
    swp = '0;
    swd = '0;
    key_ready = 1'b1;
    wait_events(6, 40, "bp_count");
    for (int i = 0; i < 6; i++) check($sformatf("bp_code%0d", i), code_at(i), bp_exp[i]);
    check("bp_throughput", cyc_at(5) - cyc_at(0), 5);
    tick(DB + 10);
    check("bp_no_extra", got.size(), 6);

    // merge: second press of a blocked pending lane
    clear_got();
    key_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_lane(mg_lanes[i], 1'b1);
      tick(DB + 10);
    end
    for (int r = 0; r < 2; r++) begin
      swp[8] = 1'b1;
      tick(DB + 10);
      swp[8] = 1'b0;
      tick(DB + 10);
    end
    check("merge_overflow", overflow, 1);
    swp = '0;
    key_ready = 1'b1;
    wait_events(5, 40, "merge_count");
    for (int i = 0; i < 5; i++) check($sformatf("merge_code%0d", i), code_at(i), mg_exp[i]);
    tick(DB + 10);
    check("merge_no_extra", got.size(), 5);
    check("merge_overflow_sticky", overflow, 1);

    // reset mid-operation with 3 events queued, one key still held
    clear_got();
    key_ready = 1'b0;
    swp[11] = 1'b1;
    tick(DB + 10);
    swd[2] = 1'b1;
    tick(DB + 10);
    swp[4] = 1'b1;
    tick(DB + 10);
    check("rstmid_valid_before", key_valid, 1);
    check("rstmid_head_before", key_code, 5'h01);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_valid", key_valid, 0);
    check("rstmid_code", key_code, 0);
    check("rstmid_overflow", overflow, 0);
    check("rstmid_held", held, 0);
    swp[11] = 1'b0;
    swd[2] = 1'b0;
    tick(2);
    rst = 1'b1;
    key_ready = 1'b1;
    vlat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (vlat < 0 && key_valid) vlat = k;
    end
    check("rstmid_redetect_latency", vlat, DB + 4);
    tick(DB + 10);
    check("rstmid_count", got.size(), 1);
    check("rstmid_code_after", code_at(0), 5'h08);
    swp = '0;
    tick(DB + 10);

    // randomized single presses with glitches and random backpressure
    clear_got();
    exp_q.delete();
    for (int it = 0; it < 25; it++) begin
      glane = $urandom_range(0, 19);
      set_lane(glane, 1'b1);
      rtick($urandom_range(1, 8));
      set_lane(glane, 1'b0);
      rtick(3);
      lane = $urandom_range(0, 19);
      set_lane(lane, 1'b1);
      exp_q.push_back(ref_code(lane));
      rtick($urandom_range(DB + 6, DB + 24));
      check($sformatf("rand%0d_held", it), held, 20'(1) << lane);
      set_lane(lane, 1'b0);
      rtick($urandom_range(DB + 6, DB + 24));
    end
    key_ready = 1'b1;
    wait_events(exp_q.size(), 40, "rand_count");
    for (int i = 0; i < exp_q.size(); i++) check($sformatf("rand_code%0d", i), code_at(i), exp_q[i]);
    check("rand_overflow", overflow, 0);
    check("rand_held_idle", held, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
